// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// UART transmitter. A winner's byte is latched in IDLE, started with a single
// enable pulse, then the arbiter waits for the transmitter to go busy and idle
// again (or gives up after BUSY_TIMEOUT cycles) before arbitrating again.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk_50m,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         grant_ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [7:0]                 uart_tx_data,
    output logic                       uart_tx_enable,
    input  logic                       uart_tx_busy,
    output logic                       arb_busy,
    output logic                       tx_timeout
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timeout_cnt;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [7:0]       winner_data;
    int               rr_dist;
    int               rr_best;

    // Round-robin search: the requester closest above the last grant wins.
    // Distance (j - grant_id - 1) mod NUM_REQ is 0 for the slot just after
    // the previous winner, so the previous winner itself ranks last.
    always_comb begin
        found       = 1'b0;
        winner      = grant_id;
        winner_data = uart_tx_data;
        rr_dist     = 0;
        rr_best     = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            rr_dist = (j + NUM_REQ - 1 - int'(grant_id)) % NUM_REQ;
            if (req[j] && (rr_dist < rr_best)) begin
                found       = 1'b1;
                rr_best     = rr_dist;
                winner      = ID_W'(j);
                winner_data = req_data[8*j +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Winner latch and busy-wait counter; the byte only changes on a new win,
    // so it stays put from START until the next arbitration.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            grant_id     <= LAST_ID;
            uart_tx_data <= 8'h00;
            timeout_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id     <= winner;
                        uart_tx_data <= winner_data;
                    end
                end
                START: begin
                    timeout_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (!uart_tx_busy) begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and decoded outputs; every pulse output is tied to a single
    // state (or a single exit condition), so none can last two cycles.
    always_comb begin
        state_next     = state;
        uart_tx_enable = 1'b0;
        grant_ack      = '0;
        tx_timeout     = 1'b0;
        arb_busy       = 1'b1;
        case (state)
            IDLE: begin
                arb_busy = 1'b0;
                if (found) begin
                    state_next = START;
                end
            end
            START: begin
                uart_tx_enable = 1'b1;
                grant_ack      = NUM_REQ'(1) << grant_id;
                state_next     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timeout_cnt == CNT_LAST) begin
                    tx_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
